// File: rtl/pls_segment_ramp.sv
// pls_segment_ramp
// Emits one linear signal segment as an AXI-Stream sample sequence. The first
// sample is start_value; each later sample is the previous one plus increment,
// summed by the shared external floating-point adder. This block does no float
// arithmetic itself.
//
// Ports
//   aclk, aresetn         clock, asynchronous active-low reset
//   start                 level request, sampled only when idle
//   start_value           first sample (float bits), captured on accepted start
//   increment             per-line increment (float bits), captured on start
//   lines                 unsigned sample count, captured on start
//   busy                  registered run-in-progress flag
//   add_a_* / add_b_*     operand streams to the external adder (acc, inc)
//   add_r_*               result stream from the external adder
//   m_*                   sample output stream, m_tlast on the final sample
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; inputs captured when start is seen
// EMIT     | presenting acc on m_*, waiting for m_tready
// ADD_REQ  | offering acc and inc to the adder, each until its own handshake
// ADD_WAIT | waiting for the adder result, which becomes the next acc
// DONE     | run finished; waits for start to drop before re-arming
module pls_segment_ramp #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] start_value,
  input  logic [DATA_SIZE-1:0] increment,
  input  logic [DATA_SIZE-1:0] lines,
  output logic                 busy,
  output logic [DATA_SIZE-1:0] add_a_tdata,
  output logic                 add_a_tvalid,
  input  logic                 add_a_tready,
  output logic [DATA_SIZE-1:0] add_b_tdata,
  output logic                 add_b_tvalid,
  input  logic                 add_b_tready,
  input  logic [DATA_SIZE-1:0] add_r_tdata,
  input  logic                 add_r_tvalid,
  output logic                 add_r_tready,
  output logic [DATA_SIZE-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EMIT     = 3'd1,
    S_ADD_REQ  = 3'd2,
    S_ADD_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [DATA_SIZE-1:0] ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1};

  state_t               state;
  logic [DATA_SIZE-1:0] acc;
  logic [DATA_SIZE-1:0] inc;
  logic [DATA_SIZE-1:0] n_lines;
  logic [DATA_SIZE-1:0] cnt;
  logic                 a_done;
  logic                 b_done;

  logic                 a_hs;
  logic                 b_hs;
  logic                 is_last;

  // All stream controls decode the registered state, so an asynchronous
  // reset drops every valid/ready in the same cycle.
  assign m_tvalid     = (state == S_EMIT);
  assign m_tdata      = acc;
  assign m_tlast      = (state == S_EMIT) && is_last;
  assign add_a_tdata  = acc;
  assign add_b_tdata  = inc;
  assign add_a_tvalid = (state == S_ADD_REQ) && !a_done;
  assign add_b_tvalid = (state == S_ADD_REQ) && !b_done;
  assign add_r_tready = (state == S_ADD_WAIT);

  assign a_hs    = add_a_tvalid && add_a_tready;
  assign b_hs    = add_b_tvalid && add_b_tready;
  // n_lines is never zero while in EMIT, so the wrap of n_lines-1 is harmless.
  assign is_last = (cnt == (n_lines - ONE));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      acc     <= '0;
      inc     <= '0;
      n_lines <= '0;
      cnt     <= '0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      busy <= (state == S_EMIT) || (state == S_ADD_REQ) || (state == S_ADD_WAIT);
      case (state)
        S_IDLE: begin
          if (start) begin
            acc     <= start_value;
            inc     <= increment;
            n_lines <= lines;
            cnt     <= '0;
            state   <= (lines == '0) ? S_DONE : S_EMIT;
          end
        end
        S_EMIT: begin
          if (m_tready) begin
            if (is_last) begin
              state <= S_DONE;
            end else begin
              cnt    <= cnt + ONE;
              a_done <= 1'b0;
              b_done <= 1'b0;
              state  <= S_ADD_REQ;
            end
          end
        end
        S_ADD_REQ: begin
          if (a_hs) a_done <= 1'b1;
          if (b_hs) b_done <= 1'b1;
          // Leave as soon as both operands are in, counting this cycle's beats.
          if ((a_done || a_hs) && (b_done || b_hs)) state <= S_ADD_WAIT;
        end
        S_ADD_WAIT: begin
          if (add_r_tvalid) begin
            acc   <= add_r_tdata;
            state <= S_EMIT;
          end
        end
        S_DONE: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pls_segment_ramp.sv
// Testbench for pls_segment_ramp. Segments use integer-valued floats so the
// reference sequence is plain integer arithmetic: sample k = start + k*inc.
module tb_pls_segment_ramp;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [31:0] start_value, increment, lines;
  logic        busy;
  logic [31:0] add_a_tdata, add_b_tdata, add_r_tdata, m_tdata;
  logic        add_a_tvalid, add_a_tready, add_b_tvalid, add_b_tready;
  logic        add_r_tvalid, add_r_tready, m_tvalid, m_tready, m_tlast;

  always #5 aclk = ~aclk;

  pls_segment_ramp #(.DATA_SIZE(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .start_value(start_value), .increment(increment), .lines(lines),
    .busy(busy),
    .add_a_tdata(add_a_tdata), .add_a_tvalid(add_a_tvalid), .add_a_tready(add_a_tready),
    .add_b_tdata(add_b_tdata), .add_b_tvalid(add_b_tvalid), .add_b_tready(add_b_tready),
    .add_r_tdata(add_r_tdata), .add_r_tvalid(add_r_tvalid), .add_r_tready(add_r_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  // Integer <-> IEEE-754 single, exact for |v| < 2^24.
  function automatic logic [31:0] i2f(input int v);
    int          mag;
    int          p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    m = 32'(mag) << (23 - p);
    return {(v < 0), 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >>> (23 - e);
    return f[31] ? -m : m;
  endfunction

  // ---------------- adder model and sink model ----------------
  int          lat, op_mode, a_wait, b_wait, sink_mode, stall_beat, stall_left;
  int          res_cd, a_vcnt, b_vcnt, n_a, n_b, n_r, n_stall, cyc;
  bit          have_a, have_b, res_busy, saw_op_valid;
  logic [31:0] a_val, b_val, res_val;
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  bit          prev_m_stall, prev_a_stall, prev_b_stall;
  logic [31:0] prev_m_data, prev_a_data, prev_b_data;
  logic        prev_m_last;

  task automatic model_clear();
    have_a = 0; have_b = 0; res_busy = 0; res_cd = 0;
    a_vcnt = 0; b_vcnt = 0; n_a = 0; n_b = 0; n_r = 0; n_stall = 0;
    saw_op_valid = 0; prev_m_stall = 0; prev_a_stall = 0; prev_b_stall = 0;
    got_data.delete(); got_last.delete(); got_cyc.delete();
    add_r_tvalid = 1'b0;
  endtask

  // Called at a falling edge: checks holds, drives this cycle's inputs, and
  // records handshakes that complete on the next rising edge.
  task automatic step();
    if (prev_m_stall) begin
      chk1("m_hold_valid", m_tvalid, 1'b1);
      chk("m_hold_data", m_tdata, prev_m_data);
      chk1("m_hold_last", m_tlast, prev_m_last);
    end
    if (prev_a_stall) begin
      chk1("a_hold_valid", add_a_tvalid, 1'b1);
      chk("a_hold_data", add_a_tdata, prev_a_data);
    end
    if (prev_b_stall) begin
      chk1("b_hold_valid", add_b_tvalid, 1'b1);
      chk("b_hold_data", add_b_tdata, prev_b_data);
    end
    if (add_a_tvalid || add_b_tvalid) saw_op_valid = 1;

    if (res_busy && res_cd > 0) res_cd--;
    add_r_tvalid = res_busy && (res_cd == 0);
    add_r_tdata  = res_val;
    if (add_r_tvalid && add_r_tready) begin
      res_busy = 0; have_a = 0; have_b = 0; n_r++;
    end

    if (op_mode == 1) begin
      add_a_tready = 1'($urandom_range(0, 1));
      add_b_tready = 1'($urandom_range(0, 1));
    end else begin
      add_a_tready = (a_vcnt >= a_wait);
      add_b_tready = (b_vcnt >= b_wait);
    end
    if (add_a_tvalid && add_a_tready) begin
      chk1("a_no_dup", have_a, 1'b0);
      have_a = 1; a_val = add_a_tdata; n_a++; a_vcnt = 0;
    end else if (add_a_tvalid) a_vcnt++;
    if (add_b_tvalid && add_b_tready) begin
      chk1("b_no_dup", have_b, 1'b0);
      have_b = 1; b_val = add_b_tdata; n_b++; b_vcnt = 0;
    end else if (add_b_tvalid) b_vcnt++;
    if (have_a && have_b && !res_busy) begin
      res_busy = 1; res_cd = lat; res_val = i2f(f2i(a_val) + f2i(b_val));
    end

    if (sink_mode == 1) m_tready = 1'($urandom_range(0, 1));
    else m_tready = !(stall_left > 0 && got_data.size() == stall_beat);
    if (m_tvalid && m_tready) begin
      got_data.push_back(m_tdata); got_last.push_back(m_tlast); got_cyc.push_back(cyc);
    end else if (m_tvalid && stall_left > 0) begin
      stall_left--; n_stall++;
    end

    prev_m_stall = m_tvalid && !m_tready;
    prev_m_data  = m_tdata;
    prev_m_last  = m_tlast;
    prev_a_stall = add_a_tvalid && !add_a_tready;
    prev_a_data  = add_a_tdata;
    prev_b_stall = add_b_tvalid && !add_b_tready;
    prev_b_data  = add_b_tdata;
    @(negedge aclk);
    cyc++;
  endtask

  // Runs one segment from a falling edge and checks timing and the full sequence.
  task automatic run_seg(input logic [31:0] sv, input logic [31:0] inc,
                         input logic [31:0] nl, input bit hold_start);
    int n;
    model_clear();
    start_value = sv; increment = inc; lines = nl; start = 1'b1;
    step();
    chk1("first_valid", m_tvalid, nl != 0);
    chk1("busy_t1", busy, 1'b0);
    step();
    chk1("busy_t2", busy, nl != 0);
    if (nl != 0) begin
      n = 0;
      while (!(got_last.size() > 0 && got_last[got_last.size()-1]) && n < 600) begin
        step(); n++;
      end
      if (n >= 600) begin
        chk1("run_timeout", 1'b0, 1'b1);
        start = 1'b0;
        return;
      end
      chk1("busy_e1", busy, 1'b1);
      chk1("valid_after_last", m_tvalid, 1'b0);
      step();
      chk1("busy_e2", busy, 1'b0);
    end else begin
      repeat (5) begin
        step();
        chk1("zero_no_valid", m_tvalid, 1'b0);
        chk1("zero_no_busy", busy, 1'b0);
      end
    end
    if (hold_start) begin
      repeat (8) begin
        step();
        chk1("hold_no_valid", m_tvalid, 1'b0);
        chk1("hold_no_busy", busy, 1'b0);
      end
    end
    start = 1'b0;
    step(); step();
    chk("beats", 32'(got_data.size()), nl);
    for (int k = 0; k < got_data.size() && k < int'(nl); k++) begin
      chk($sformatf("data%0d", k), got_data[k], i2f(f2i(sv) + k * f2i(inc)));
      chk1($sformatf("last%0d", k), got_last[k], k == int'(nl) - 1);
    end
    chk("ops_a", 32'(n_a), (nl == 0) ? 32'd0 : nl - 32'd1);
    chk("ops_b", 32'(n_b), (nl == 0) ? 32'd0 : nl - 32'd1);
    chk("ops_r", 32'(n_r), (nl == 0) ? 32'd0 : nl - 32'd1);
    if (nl <= 1) chk1("no_op_valid", saw_op_valid, 1'b0);
  endtask

  typedef struct {
    logic [31:0] sv;
    logic [31:0] inc;
    logic [31:0] nl;
    int          lat;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{32'h00000000, 32'h3F800000, 32'd4, 1, 4, 32'h40400000};
    vt[1] = '{32'h40A00000, 32'h3F800000, 32'd1, 1, 1, 32'h40A00000};
    vt[2] = '{32'h00000000, 32'h3F800000, 32'd0, 1, 0, 32'h00000000};
    vt[3] = '{32'h41200000, 32'hC0000000, 32'd6, 2, 6, 32'h00000000};
    vt[4] = '{32'h3F800000, 32'h40000000, 32'd3, 3, 3, 32'h40A00000};

    cyc = 0; lat = 1; op_mode = 0; a_wait = 0; b_wait = 0;
    sink_mode = 0; stall_beat = 0; stall_left = 0;
    aresetn = 1'b0; start = 1'b0; start_value = '0; increment = '0; lines = '0;
    add_a_tready = 1'b0; add_b_tready = 1'b0; add_r_tdata = '0; m_tready = 1'b0;
    res_val = '0; a_val = '0; b_val = '0;
    model_clear();
    @(negedge aclk); @(negedge aclk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_m_tvalid", m_tvalid, 1'b0);
    chk1("rst_m_tlast", m_tlast, 1'b0);
    chk1("rst_a_tvalid", add_a_tvalid, 1'b0);
    chk1("rst_b_tvalid", add_b_tvalid, 1'b0);
    chk1("rst_r_tready", add_r_tready, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_a_tdata", add_a_tdata, 32'h0);
    chk("rst_b_tdata", add_b_tdata, 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Directed table: always-ready sink and adder, period must be 2+L.
    for (int i = 0; i < 5; i++) begin
      lat = vt[i].lat; op_mode = 0; a_wait = 0; b_wait = 0; sink_mode = 0;
      run_seg(vt[i].sv, vt[i].inc, vt[i].nl, 1'b0);
      chk($sformatf("tbl%0d_beats", i), 32'(got_data.size()), 32'(vt[i].exp_beats));
      if (got_data.size() > 0)
        chk($sformatf("tbl%0d_last_data", i), got_data[got_data.size()-1], vt[i].exp_last);
      for (int k = 1; k < got_cyc.size(); k++)
        chk($sformatf("tbl%0d_period%0d", i, k), 32'(got_cyc[k] - got_cyc[k-1]), 32'(2 + vt[i].lat));
    end

    // Output stall on beat 2 for 5 cycles.
    lat = 1; sink_mode = 0; stall_beat = 1; stall_left = 5;
    run_seg(i2f(3), i2f(4), 32'd4, 1'b0);
    chk("stall_cycles", 32'(n_stall), 32'd5);
    stall_left = 0;

    // Operand A accepted on cycle N, operand B on N+3.
    op_mode = 0; a_wait = 0; b_wait = 3;
    run_seg(i2f(-5), i2f(2), 32'd4, 1'b0);
    b_wait = 0;

    // Reset while waiting on the adder, then restart from new inputs.
    model_clear();
    lat = 6; start_value = i2f(1); increment = i2f(1); lines = 32'd8; start = 1'b1;
    n = 0;
    while (!add_r_tready && n < 100) begin step(); n++; end
    chk1("reach_add_wait", add_r_tready, 1'b1);
    aresetn = 1'b0;
    #1;
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_m_tvalid", m_tvalid, 1'b0);
    chk1("mrst_m_tlast", m_tlast, 1'b0);
    chk1("mrst_a_tvalid", add_a_tvalid, 1'b0);
    chk1("mrst_b_tvalid", add_b_tvalid, 1'b0);
    chk1("mrst_r_tready", add_r_tready, 1'b0);
    chk("mrst_m_tdata", m_tdata, 32'h0);
    add_r_tvalid = 1'b1; add_r_tdata = 32'h12345678;
    start_value = i2f(7); increment = i2f(-3); lines = 32'd3;
    @(negedge aclk); @(negedge aclk);
    chk1("mrst_r_tready_hold", add_r_tready, 1'b0);
    chk1("mrst_valid_hold", m_tvalid, 1'b0);
    add_r_tvalid = 1'b0;
    aresetn = 1'b1;
    lat = 1;
    run_seg(i2f(7), i2f(-3), 32'd3, 1'b0);

    // start held after DONE must not retrigger; then a fresh 2-beat run.
    run_seg(i2f(2), i2f(5), 32'd3, 1'b1);
    run_seg(i2f(9), i2f(1), 32'd2, 1'b0);

    // Randomized segments with random backpressure and adder latency.
    sink_mode = 1; op_mode = 1;
    for (int r = 0; r < 20; r++) begin
      lat = int'($urandom_range(1, 4));
      run_seg(i2f(int'($urandom_range(0, 2000)) - 1000),
              i2f(int'($urandom_range(0, 100)) - 50),
              32'($urandom_range(0, 9)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pls_segment_ramp.md
# pls_segment_ramp

Downstream consumer of the increment calculator in the configuration/playback path. It takes one signal segment (start value, per-line increment, line count) and emits the segment's sample sequence on an AXI-Stream output. Each sample is the previous sample plus the increment, computed with the shared external floating-point adder over AXI-Stream. It uses the same level start/busy handshake as the other configuration services.

## Interface
- DATA_SIZE, 32, width of sample/increment words (IEEE-754 single) and of the line counter
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  level request; sampled only in IDLE
- start_value  in  DATA_SIZE  first sample (float bits); captured on accepted start
- increment  in  DATA_SIZE  per-line increment (float bits), i.e. calculator result; captured on accepted start
- lines  in  DATA_SIZE  unsigned number of samples to emit; captured on accepted start
- busy  out  1  run in progress
- add_a_tdata / add_a_tvalid / add_a_tready  out/out/in  DATA_SIZE/1/1  adder operand A
- add_b_tdata / add_b_tvalid / add_b_tready  out/out/in  DATA_SIZE/1/1  adder operand B
- add_r_tdata / add_r_tvalid / add_r_tready  in/in/out  DATA_SIZE/1/1  adder result
- m_tdata / m_tvalid / m_tready / m_tlast  out/out/in/out  DATA_SIZE/1/1/1  sample stream

## Operation
- Registers: acc (current sample), inc, n_lines, cnt (samples emitted), a_done, b_done.
- States: IDLE, EMIT, ADD_REQ, ADD_WAIT, DONE.
- IDLE, start=1:
  - Capture start_value→acc, increment→inc, lines→n_lines; cnt←0.
  - Go to EMIT, or to DONE if lines==0.
- EMIT:
  - m_tvalid=1, m_tdata=acc, m_tlast=(cnt==n_lines-1).
  - On m_tready: if last, go to DONE; else cnt←cnt+1, clear a_done/b_done, go to ADD_REQ.
- ADD_REQ:
  - add_a_tdata=acc, add_b_tdata=inc.
  - add_a_tvalid=!a_done and add_b_tvalid=!b_done; each is set done on its own handshake.
  - Operands may be accepted in different cycles. When both are accepted (including the current cycle), go to ADD_WAIT.
- ADD_WAIT:
  - add_r_tready=1.
  - On add_r_tvalid: acc←add_r_tdata, go to EMIT.
- DONE: when start==0, go to IDLE. A start held high never retriggers.
- busy: registered; next value is 1 in EMIT/ADD_REQ/ADD_WAIT and 0 in IDLE/DONE.
- start is ignored outside IDLE/DONE. Deasserting it mid-run does not abort the run.
- No float arithmetic is done locally. cnt compare is unsigned DATA_SIZE-bit, so lines up to 2^DATA_SIZE-1 are supported.
- Any state code outside the enum goes to IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE; all registers 0; busy, m_tvalid, m_tlast, add_*_tvalid and add_r_tready are 0.
- Reset asserted mid-run takes effect immediately: every valid drops in the same cycle, and a partial adder result arriving later is dropped.
- Stall behaviour:
  - m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
  - add_a/add_b data stay stable until their own handshake.
- Latency:
  - Start sampled at edge T: first m_tvalid at T+1; busy=1 from T+2.
  - The final m_tready handshake at edge E moves the FSM to DONE; busy=0 from E+1.
- Throughput:
  - With m_tready=1, both operands accepted immediately and result valid L cycles after acceptance, the sample period is 2+L cycles.
  - With L=1, that is 3 cycles per sample.
- lines==0: IDLE→DONE directly, busy never rises, no output beat and no adder transaction.
- lines==1: one beat with m_tlast=1, no adder transaction.

## Test plan
- start_value=0x00000000, increment=0x3F800000, lines=4, model adder L=1, m_tready=1 → m_tdata 0x00000000, 0x3F800000, 0x40000000, 0x40400000; tlast only on the 4th beat; exactly 3 adder transactions; busy low one cycle after the last beat.
- lines=1, start_value=0x40A00000 → single beat 0x40A00000 with tlast; add_*_tvalid never asserted.
- lines=0 → no m_tvalid, busy stays 0; FSM returns to IDLE when start falls.
- Stalls:
  - Hold m_tready=0 for 5 cycles on beat 2 → m_tdata/m_tlast stable throughout.
  - add_a_tready on cycle N, add_b_tready on N+3 → each valid drops after its own handshake, with no duplicate operand beats.
- Assert aresetn=0 during ADD_WAIT of a lines=8 run → all outputs 0 immediately. After release with start still 1, a new run starts from the newly captured inputs.
- Keep start=1 after DONE → no second run. Drop start, then raise it with lines=2 → a fresh 2-beat run.
